// File: rtl/exec_sequencer_pkg.sv
// Shared control-unit state codes and T-step codes for the execution sequencer.
package exec_sequencer_pkg;

    localparam logic [7:0] STATE_NEXT       = 8'h00;
    localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
    localparam logic [7:0] STATE_FETCH_INST = 8'h02;
    localparam logic [7:0] STATE_HALT       = 8'h03;
    localparam logic [7:0] STATE_JUMP       = 8'h04;
    localparam logic [7:0] STATE_SET_REG    = 8'h05;
    localparam logic [7:0] STATE_ALU_EXEC   = 8'h06;
    localparam logic [7:0] STATE_ALU_STORE  = 8'h07;
    localparam logic [7:0] STATE_MOV_FETCH  = 8'h08;
    localparam logic [7:0] STATE_MOV_LOAD   = 8'h09;
    localparam logic [7:0] STATE_MOV__STORE = 8'h0A;

    typedef enum logic [7:0] {
        T1 = 8'h01,
        T2 = 8'h02,
        T3 = 8'h04,
        T4 = 8'h08,
        T5 = 8'h10
    } tstep_e;

endpackage

// File: rtl/exec_sequencer.sv
// Execution sequencer: T-step counter, PC/MAR/IR registers and
// register-file / memory / ALU strobes decoded from the control-unit state.
module exec_sequencer
    import exec_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] state,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] reg_rdata,
    input  logic [7:0] alu_result,
    output logic [7:0] cycle,
    output logic [3:0] opcode,
    output logic [7:0] instruction,
    output logic [7:0] pc,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic [1:0] reg_raddr,
    output logic [1:0] reg_waddr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       alu_en,
    output logic       halted
);

    tstep_e     r_cycle;
    tstep_e     w_cycle_nxt;
    logic [7:0] r_pc;
    logic [7:0] r_mem_addr;
    logic [7:0] r_instruction;
    logic [7:0] r_tmp;
    logic       r_halted;
    logic       w_active;

    // Strobes are also gated by reset so an asserted reset kills them at once.
    assign w_active = reset && !r_halted;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= T1;
        end else begin
            r_cycle <= w_cycle_nxt;
        end
    end

    always_comb begin
        w_cycle_nxt = r_cycle;
        if (!r_halted) begin
            if (state == STATE_NEXT) begin
                w_cycle_nxt = T1;
            end else begin
                case (r_cycle)
                    T1:      w_cycle_nxt = T2;
                    T2:      w_cycle_nxt = T3;
                    T3:      w_cycle_nxt = T4;
                    T4:      w_cycle_nxt = T5;
                    T5:      w_cycle_nxt = T1;
                    default: w_cycle_nxt = T1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= 8'h00;
            r_mem_addr    <= 8'h00;
            r_instruction <= 8'h00;
            r_tmp         <= 8'h00;
            r_halted      <= 1'b0;
        end else if (!r_halted) begin
            case (state)
                STATE_HALT: begin
                    r_halted <= 1'b1;
                end
                STATE_FETCH_PC: begin
                    r_mem_addr <= r_pc;
                    r_pc       <= r_pc + 8'd1;
                end
                STATE_FETCH_INST: begin
                    r_instruction <= mem_rdata;
                end
                STATE_JUMP: begin
                    r_pc <= mem_rdata;
                end
                STATE_MOV_LOAD: begin
                    r_tmp <= reg_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        reg_we    = 1'b0;
        alu_en    = 1'b0;
        reg_waddr = 2'd0;
        reg_wdata = 8'h00;
        if (w_active) begin
            case (state)
                STATE_FETCH_INST,
                STATE_JUMP: begin
                    mem_rd = 1'b1;
                end
                STATE_SET_REG: begin
                    mem_rd    = 1'b1;
                    reg_we    = 1'b1;
                    reg_waddr = r_instruction[1:0];
                    reg_wdata = mem_rdata;
                end
                STATE_ALU_EXEC: begin
                    alu_en = 1'b1;
                end
                STATE_ALU_STORE: begin
                    reg_we    = 1'b1;
                    reg_waddr = r_instruction[1:0];
                    reg_wdata = alu_result;
                end
                STATE_MOV__STORE: begin
                    reg_we    = 1'b1;
                    reg_waddr = r_instruction[1:0];
                    reg_wdata = r_tmp;
                end
                default: ;
            endcase
        end
    end

    assign cycle       = r_cycle;
    assign opcode      = r_instruction[7:4];
    assign instruction = r_instruction;
    assign pc          = r_pc;
    assign mem_addr    = r_mem_addr;
    assign reg_raddr   = r_instruction[3:2];
    assign halted      = r_halted;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized scoreboard bench for exec_sequencer against a behavioural model.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] state;
    logic [7:0] mem_rdata;
    logic [7:0] reg_rdata;
    logic [7:0] alu_result;
    logic [7:0] cycle;
    logic [3:0] opcode;
    logic [7:0] instruction;
    logic [7:0] pc;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [1:0] reg_raddr;
    logic [1:0] reg_waddr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       alu_en;
    logic       halted;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .mem_rdata   (mem_rdata),
        .reg_rdata   (reg_rdata),
        .alu_result  (alu_result),
        .cycle       (cycle),
        .opcode      (opcode),
        .instruction (instruction),
        .pc          (pc),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .reg_raddr   (reg_raddr),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .alu_en      (alu_en),
        .halted      (halted)
    );

    typedef struct packed {
        logic [7:0] cycle;
        logic [3:0] opcode;
        logic [7:0] instruction;
        logic [7:0] pc;
        logic [7:0] mem_addr;
        logic       mem_rd;
        logic [1:0] raddr;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic       we;
        logic       alu;
        logic       halted;
    } exp_t;

    exp_t  sb[$];
    string tq[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    // Behavioural model: T-step index 0..4 and plain integer registers.
    int m_step;
    int m_pc;
    int m_mar;
    int m_ir;
    int m_tmp;
    bit m_halt;

    function automatic logic [7:0] t_of(int i);
        case (i)
            0:       return T1;
            1:       return T2;
            2:       return T3;
            3:       return T4;
            default: return T5;
        endcase
    endfunction

    function automatic void m_reset();
        m_step = 0;
        m_pc   = 0;
        m_mar  = 0;
        m_ir   = 0;
        m_tmp  = 0;
        m_halt = 0;
    endfunction

    function automatic void m_advance();
        if (m_halt) return;
        m_step = (state == STATE_NEXT) ? 0 : (m_step + 1) % 5;
        case (state)
            STATE_HALT:       m_halt = 1;
            STATE_FETCH_PC: begin
                m_mar = m_pc;
                m_pc  = (m_pc + 1) % 256;
            end
            STATE_FETCH_INST: m_ir  = int'(mem_rdata);
            STATE_JUMP:       m_pc  = int'(mem_rdata);
            STATE_MOV_LOAD:   m_tmp = int'(reg_rdata);
            default: ;
        endcase
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        e             = '0;
        e.cycle       = t_of(m_step);
        e.instruction = 8'(m_ir);
        e.opcode      = 4'(m_ir / 16);
        e.pc          = 8'(m_pc);
        e.mem_addr    = 8'(m_mar);
        e.raddr       = 2'((m_ir / 4) % 4);
        e.halted      = m_halt;
        if (reset && !m_halt) begin
            case (state)
                STATE_FETCH_INST: e.mem_rd = 1'b1;
                STATE_JUMP:       e.mem_rd = 1'b1;
                STATE_SET_REG: begin
                    e.mem_rd = 1'b1;
                    e.we     = 1'b1;
                    e.waddr  = 2'(m_ir % 4);
                    e.wdata  = mem_rdata;
                end
                STATE_ALU_EXEC:   e.alu = 1'b1;
                STATE_ALU_STORE: begin
                    e.we    = 1'b1;
                    e.waddr = 2'(m_ir % 4);
                    e.wdata = alu_result;
                end
                STATE_MOV__STORE: begin
                    e.we    = 1'b1;
                    e.waddr = 2'(m_ir % 4);
                    e.wdata = 8'(m_tmp);
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag, input string f,
                       input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %h expected %h at %0t",
                     tag, f, act, exp, $time);
        end
    endtask

    task automatic check_all(input exp_t e, input string tag);
        chk(tag, "cycle",       cycle,              e.cycle);
        chk(tag, "opcode",      {4'h0, opcode},     {4'h0, e.opcode});
        chk(tag, "instruction", instruction,        e.instruction);
        chk(tag, "pc",          pc,                 e.pc);
        chk(tag, "mem_addr",    mem_addr,           e.mem_addr);
        chk(tag, "mem_rd",      {7'h0, mem_rd},     {7'h0, e.mem_rd});
        chk(tag, "reg_raddr",   {6'h0, reg_raddr},  {6'h0, e.raddr});
        chk(tag, "reg_waddr",   {6'h0, reg_waddr},  {6'h0, e.waddr});
        chk(tag, "reg_wdata",   reg_wdata,          e.wdata);
        chk(tag, "reg_we",      {7'h0, reg_we},     {7'h0, e.we});
        chk(tag, "alu_en",      {7'h0, alu_en},     {7'h0, e.alu});
        chk(tag, "halted",      {7'h0, halted},     {7'h0, e.halted});
    endtask

    // Monitor: every cycle the DUT presents a full output set at negedge.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                t = tq.pop_front();
                check_all(e, t);
            end
        end
    end

    task automatic step(input logic [7:0] st, input logic [7:0] mr,
                        input logic [7:0] rr, input logic [7:0] al,
                        input string tag);
        @(posedge clk);
        if (reset) m_advance();
        #1;
        state      = st;
        mem_rdata  = mr;
        reg_rdata  = rr;
        alu_result = al;
        sb.push_back(m_expect());
        tq.push_back(tag);
    endtask

    task automatic rstep(input logic [7:0] st, input string tag);
        step(st, 8'($urandom), 8'($urandom), 8'($urandom), tag);
    endtask

    // Reset asserted between edges; held over one edge, released before the next.
    task automatic reset_pulse();
        #6;
        reset = 1'b0;
        m_reset();
        #1;
        check_all(m_expect(), "async_rst");
        rstep(8'hFF, "rst_hold");
        #6;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        logic [7:0] st;
        reset      = 1'b0;
        state      = 8'hFF;
        mem_rdata  = 8'h00;
        reg_rdata  = 8'h00;
        alu_result = 8'h00;
        m_reset();

        rstep(8'hFF, "reset");
        rstep(8'hFF, "reset");
        #6;
        reset = 1'b1;

        repeat (6) rstep(8'hFF, "free_run");

        step(STATE_JUMP, 8'hFF, 8'h00, 8'h00, "jump_ff");
        rstep(STATE_FETCH_PC, "fetch_pc_wrap");
        rstep(8'hFF, "pc_wrapped");

        step(STATE_FETCH_INST, 8'hA3, 8'h00, 8'h00, "fetch_a3");
        step(STATE_JUMP, 8'h40, 8'h00, 8'h00, "jump_40");
        rstep(8'hFF, "after_jump");

        step(STATE_FETCH_INST, 8'h0E, 8'h00, 8'h00, "fetch_0e");
        rstep(STATE_MOV_FETCH, "mov_fetch");
        step(STATE_MOV_LOAD, 8'h00, 8'h5C, 8'h00, "mov_load");
        rstep(STATE_MOV__STORE, "mov_store");
        rstep(8'hFF, "after_mov");

        rstep(STATE_SET_REG, "set_reg");
        rstep(STATE_ALU_EXEC, "alu_exec");
        rstep(STATE_ALU_STORE, "alu_store");
        rstep(8'hFF, "after_alu");

        guard = 0;
        while (m_step != 3 && guard < 10) begin
            rstep(8'hFF, "seek_t4");
            guard++;
        end
        rstep(STATE_NEXT, "next_at_t4");
        rstep(8'hFF, "after_next");

        rstep(STATE_HALT, "halt");
        for (int i = 0; i < 10; i++) begin
            rstep(8'($urandom_range(0, 10)), "halted_hold");
        end

        rstep(STATE_ALU_STORE, "alu_store_rst");
        reset_pulse();
        rstep(8'hFF, "post_rst");

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                st = STATE_HALT;
            end else if (r < 10) begin
                st = 8'($urandom);
                if (st == STATE_HALT) st = 8'hFF;
            end else begin
                st = 8'($urandom_range(0, 10));
                if (st == STATE_HALT) st = STATE_FETCH_PC;
            end
            rstep(st, "random");
            if ($urandom_range(0, 49) == 0) reset_pulse();
        end

        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset (0 = reset asserted).
REQ-002 The block SHALL have input state  in  8: control-unit state code (shared `STATE_*` encodings from the parameter file).
REQ-003 The block SHALL have input mem_rdata  in  8: asynchronous program-memory read data for mem_addr, valid in the same cycle.
REQ-004 The block SHALL have inputs reg_rdata  in  8 (register-file read data for reg_raddr, same cycle) and alu_result  in  8 (ALU output).
REQ-005 The block SHALL have outputs cycle  out  8: current T-step (shared `T1`..`T5` codes); opcode  out  4: instruction[7:4]; instruction  out  8: instruction register.
REQ-006 The block SHALL have outputs pc  out  8: program counter; mem_addr  out  8: memory address register (MAR); mem_rd  out  1: memory read strobe.
REQ-007 The block SHALL have outputs reg_raddr  out  2, reg_waddr  out  2, reg_wdata  out  8, reg_we  out  1 (register-file port), alu_en  out  1, and halted  out  1.

Function
REQ-008 cycle SHALL advance one step per clock: T1->T2->T3->T4->T5->T1, wrapping after T5.
REQ-009 If state==`STATE_NEXT`, the next cycle value SHALL be T1, overriding the normal advance in REQ-008.
REQ-010 If state==`STATE_HALT`, halted SHALL be set at the next edge and stay set until reset; while halted, cycle, pc, mem_addr and instruction SHALL hold, and reg_we, alu_en and mem_rd SHALL be 0.
REQ-011 `STATE_FETCH_PC`: mem_addr <= pc; pc <= pc+1 modulo 256, so 0xFF wraps to 0x00.
REQ-012 `STATE_FETCH_INST`: mem_rd=1 (combinational); instruction <= mem_rdata.
REQ-013 `STATE_JUMP`: mem_rd=1; pc <= mem_rdata. This write SHALL override any increment in the same cycle.
REQ-014 `STATE_SET_REG`: mem_rd=1; reg_we=1, reg_waddr=instruction[1:0], reg_wdata=mem_rdata, all combinational in that cycle.
REQ-015 `STATE_ALU_EXEC`: alu_en=1 for exactly that cycle.
REQ-016 `STATE_ALU_STORE`: reg_we=1, reg_waddr=instruction[1:0], reg_wdata=alu_result.
REQ-017 `STATE_MOV_FETCH`: reg_raddr=instruction[3:2]; `STATE_MOV_LOAD`: internal tmp <= reg_rdata with reg_raddr=instruction[3:2].
REQ-018 `STATE_MOV__STORE`: reg_we=1, reg_waddr=instruction[1:0], reg_wdata=tmp.
REQ-019 Any other state code SHALL produce no register, memory or ALU strobe and SHALL only advance cycle per REQ-008.
REQ-020 reg_we, alu_en and mem_rd SHALL be decoded combinationally from the current state and halted, with no extra latency; all register updates SHALL occur on the same rising edge.
REQ-021 When reg_we=0, reg_waddr and reg_wdata SHALL be 0, and reg_raddr SHALL be instruction[3:2].
REQ-022 opcode SHALL always equal instruction[7:4].

Reset
REQ-023 While reset==0, and immediately on its falling edge regardless of clk, the block SHALL set cycle=`T1`, pc=0x00, mem_addr=0x00, instruction=0x00, tmp=0x00 and halted=0; reg_we, alu_en and mem_rd SHALL therefore be 0.
REQ-024 Reset asserted mid-instruction SHALL abandon that instruction without completing any pending register write.
REQ-025 After reset is released, the first rising edge SHALL advance cycle to T2.

Verification
REQ-026 Free run with state held at an unused code -> cycle T1,T2,T3,T4,T5,T1 on consecutive edges; no strobes.
REQ-027 pc=0xFF, state=`STATE_FETCH_PC` -> mem_addr=0xFF, pc=0x00 after the edge.
REQ-028 Fetch sequence with mem_rdata=0xA3 during `STATE_FETCH_INST` -> instruction=0xA3, opcode=0xA; then `STATE_JUMP` with mem_rdata=0x40 -> pc=0x40.
REQ-029 instruction=0x0E: `STATE_MOV_FETCH`, then `STATE_MOV_LOAD` with reg_rdata=0x5C, then `STATE_MOV__STORE` -> reg_raddr=3 during fetch/load; single reg_we pulse with waddr=2, wdata=0x5C.
REQ-030 `STATE_NEXT` presented while cycle=T4 -> cycle=T1 next edge; `STATE_HALT` -> halted=1, cycle and pc frozen over 10 clocks, reg_we/alu_en/mem_rd stay 0.
REQ-031 reset pulsed low between clock edges during `STATE_ALU_STORE` -> outputs reach reset values immediately, no reg_we pulse, halted cleared.
